// File: rtl/tlb_mmu_if.sv
// Request/response handshake bundle between a translation client and tlb_mmu.
interface tlb_mmu_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_vaddr;
    logic        req_store;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_paddr;
    logic        resp_uncached;
    logic [1:0]  resp_exc;

    modport master (
        output req_valid, req_vaddr, req_store, resp_ready,
        input  req_ready, resp_valid, resp_paddr, resp_uncached, resp_exc
    );

    modport slave (
        input  req_valid, req_vaddr, req_store, resp_ready,
        output req_ready, resp_valid, resp_paddr, resp_uncached, resp_exc
    );
endinterface

// File: rtl/tlb_mmu.sv
// Fully associative TLB with single-stage registered address translation,
// MIPS-style segment decode, entry write/flush and a probe port.
module tlb_mmu #(
    parameter int unsigned  TLB_ENTRIES = 16,
    parameter int unsigned  ASID_W      = 8,
    parameter int unsigned  MAPPED_USEG = 1,
    localparam int unsigned IW          = $clog2(TLB_ENTRIES),
    localparam int unsigned EW          = 43 + ASID_W,
    localparam int unsigned KW          = 20 + ASID_W
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [ASID_W-1:0] asid,
    tlb_mmu_if.slave          bus,
    input  logic              tlbw_en,
    input  logic [IW-1:0]     tlbw_index,
    input  logic [EW-1:0]     tlbw_entry,
    input  logic              tlb_flush,
    input  logic              tlbp_en,
    input  logic [KW-1:0]     tlbp_key,
    output logic              tlbp_hit,
    output logic [IW-1:0]     tlbp_index
);

    localparam logic [1:0] ExcNone   = 2'b00;
    localparam logic [1:0] ExcRefill = 2'b01;
    localparam logic [1:0] ExcInv    = 2'b10;
    localparam logic [1:0] ExcMod    = 2'b11;

    // Entry storage; only v and g carry a reset value.
    logic [19:0]            vpn_q  [TLB_ENTRIES];
    logic [ASID_W-1:0]      asid_q [TLB_ENTRIES];
    logic [19:0]            pfn_q  [TLB_ENTRIES];
    logic [TLB_ENTRIES-1:0] d_q;
    logic [TLB_ENTRIES-1:0] v_q, v_d;
    logic [TLB_ENTRIES-1:0] g_q, g_d;

    // Write-port field unpack: {vpn, asid, g, pfn, v, d}, MSB first.
    logic [19:0]       w_vpn;
    logic [ASID_W-1:0] w_asid;
    logic              w_g;
    logic [19:0]       w_pfn;
    logic              w_v;
    logic              w_d;

    assign w_d    = tlbw_entry[0];
    assign w_v    = tlbw_entry[1];
    assign w_pfn  = tlbw_entry[21:2];
    assign w_g    = tlbw_entry[22];
    assign w_asid = tlbw_entry[22+ASID_W:23];
    assign w_vpn  = tlbw_entry[42+ASID_W:23+ASID_W];

    logic [19:0]       p_vpn;
    logic [ASID_W-1:0] p_asid;

    assign p_asid = tlbp_key[ASID_W-1:0];
    assign p_vpn  = tlbp_key[19+ASID_W:ASID_W];

    // Response registers
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_paddr_q, resp_paddr_d;
    logic        resp_unc_q, resp_unc_d;
    logic [1:0]  resp_exc_q, resp_exc_d;
    logic        tlbp_hit_q;
    logic [IW-1:0] tlbp_index_q;

    logic accept;
    assign bus.req_ready = !resp_valid_q || bus.resp_ready;
    assign accept        = bus.req_valid && bus.req_ready;

    // Translation lookup: scan downwards so the lowest matching index wins.
    logic          lk_hit;
    logic [IW-1:0] lk_idx;
    always_comb begin
        lk_hit = 1'b0;
        lk_idx = '0;
        for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
            if (vpn_q[i] == bus.req_vaddr[31:12] && (g_q[i] || asid_q[i] == asid)) begin
                lk_hit = 1'b1;
                lk_idx = IW'(i);
            end
        end
    end

    // Probe lookup: same match rule, v is ignored.
    logic          pr_hit;
    logic [IW-1:0] pr_idx;
    always_comb begin
        pr_hit = 1'b0;
        pr_idx = '0;
        for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
            if (vpn_q[i] == p_vpn && (g_q[i] || asid_q[i] == p_asid)) begin
                pr_hit = 1'b1;
                pr_idx = IW'(i);
            end
        end
    end

    // Next v/g state: flush clears everything first, then a same-edge write lands on top.
    always_comb begin
        v_d = v_q;
        g_d = g_q;
        if (tlb_flush) begin
            v_d = '0;
            g_d = '0;
        end
        if (tlbw_en) begin
            v_d[tlbw_index] = w_v;
            g_d[tlbw_index] = w_g;
        end
    end

    // v/g bits with asynchronous clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            v_q <= '0;
            g_q <= '0;
        end else begin
            v_q <= v_d;
            g_q <= g_d;
        end
    end

    // Non-reset entry payload.
    always_ff @(posedge clk) begin
        if (tlbw_en) begin
            vpn_q[tlbw_index]  <= w_vpn;
            asid_q[tlbw_index] <= w_asid;
            pfn_q[tlbw_index]  <= w_pfn;
            d_q[tlbw_index]    <= w_d;
        end
    end

    // Segment decode and TLB result selection for an accepted request.
    logic [2:0] seg;
    assign seg = bus.req_vaddr[31:29];

    always_comb begin
        resp_valid_d = resp_valid_q;
        resp_paddr_d = resp_paddr_q;
        resp_unc_d   = resp_unc_q;
        resp_exc_d   = resp_exc_q;
        if (accept) begin
            resp_valid_d = 1'b1;
            resp_unc_d   = 1'b0;
            resp_exc_d   = ExcNone;
            if (seg == 3'b100 || seg == 3'b101) begin
                resp_paddr_d = {3'b000, bus.req_vaddr[28:0]};
                resp_unc_d   = seg[0];
            end else if (MAPPED_USEG == 0) begin
                resp_paddr_d = bus.req_vaddr;
            end else if (!lk_hit) begin
                resp_paddr_d = bus.req_vaddr;
                resp_exc_d   = ExcRefill;
            end else begin
                resp_paddr_d = {pfn_q[lk_idx], bus.req_vaddr[11:0]};
                if (!v_q[lk_idx]) begin
                    resp_exc_d = ExcInv;
                end else if (bus.req_store && !d_q[lk_idx]) begin
                    resp_exc_d = ExcMod;
                end
            end
        end else if (bus.resp_ready) begin
            resp_valid_d = 1'b0;
        end
    end

    // Response stage register; a pending result is dropped on reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            resp_valid_q <= 1'b0;
            resp_paddr_q <= '0;
            resp_unc_q   <= 1'b0;
            resp_exc_q   <= ExcNone;
        end else begin
            resp_valid_q <= resp_valid_d;
            resp_paddr_q <= resp_paddr_d;
            resp_unc_q   <= resp_unc_d;
            resp_exc_q   <= resp_exc_d;
        end
    end

    // Probe result register, held until the next probe.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tlbp_hit_q   <= 1'b0;
            tlbp_index_q <= '0;
        end else if (tlbp_en) begin
            tlbp_hit_q   <= pr_hit;
            tlbp_index_q <= pr_idx;
        end
    end

    assign bus.resp_valid    = resp_valid_q;
    assign bus.resp_paddr    = resp_paddr_q;
    assign bus.resp_uncached = resp_unc_q;
    assign bus.resp_exc      = resp_exc_q;
    assign tlbp_hit          = tlbp_hit_q;
    assign tlbp_index        = tlbp_index_q;

endmodule

// File: tb/tb_tlb_mmu.sv
// Scoreboard bench for tlb_mmu: mapped instance under full stimulus plus a
// legacy-mapping instance for pass-through checks.
module tb_tlb_mmu;

    localparam int unsigned N  = 16;
    localparam int unsigned AW = 8;
    localparam int unsigned IW = 4;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic [AW-1:0] asid;
    logic          tlbw_en;
    logic [IW-1:0] tlbw_index;
    logic [50:0]   tlbw_entry;
    logic          tlb_flush;
    logic          tlbp_en;
    logic [27:0]   tlbp_key;
    logic          tlbp_hit, tlbp_hit0;
    logic [IW-1:0] tlbp_index, tlbp_index0;

    always #5 clk = ~clk;

    tlb_mmu_if bus ();
    tlb_mmu_if bus0 ();

    tlb_mmu #(.TLB_ENTRIES(N), .ASID_W(AW), .MAPPED_USEG(1)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .asid       (asid),
        .bus        (bus.slave),
        .tlbw_en    (tlbw_en),
        .tlbw_index (tlbw_index),
        .tlbw_entry (tlbw_entry),
        .tlb_flush  (tlb_flush),
        .tlbp_en    (tlbp_en),
        .tlbp_key   (tlbp_key),
        .tlbp_hit   (tlbp_hit),
        .tlbp_index (tlbp_index)
    );

    tlb_mmu #(.TLB_ENTRIES(N), .ASID_W(AW), .MAPPED_USEG(0)) dut0 (
        .clk        (clk),
        .resetn     (resetn),
        .asid       (asid),
        .bus        (bus0.slave),
        .tlbw_en    (tlbw_en),
        .tlbw_index (tlbw_index),
        .tlbw_entry (tlbw_entry),
        .tlb_flush  (tlb_flush),
        .tlbp_en    (tlbp_en),
        .tlbp_key   (tlbp_key),
        .tlbp_hit   (tlbp_hit0),
        .tlbp_index (tlbp_index0)
    );

    typedef struct packed {
        logic [31:0] paddr;
        logic        unc;
        logic [1:0]  exc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   fails = 0;
    int   delivered = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [50:0] make_entry(input logic [19:0] vpn, input logic [7:0] a,
                                               input logic g, input logic [19:0] pfn,
                                               input logic v, input logic d);
        return {vpn, a, g, pfn, v, d};
    endfunction

    // Response monitor: compare the head of the scoreboard whenever a result is visible.
    always @(negedge clk) begin
        if (resetn && bus.resp_valid) begin
            if (sb.size() == 0) begin
                check_val("spurious_resp", bus.resp_valid, 0);
            end else begin
                check_val("resp_paddr", bus.resp_paddr, sb[0].paddr);
                check_val("resp_uncached", bus.resp_uncached, sb[0].unc);
                check_val("resp_exc", bus.resp_exc, sb[0].exc);
                if (bus.resp_ready) begin
                    void'(sb.pop_front());
                    delivered++;
                end else begin
                    check_val("req_ready_stall", bus.req_ready, 0);
                end
            end
        end
    end

    task automatic write_entry(input logic [IW-1:0] idx, input logic [50:0] e);
        tlbw_en    = 1'b1;
        tlbw_index = idx;
        tlbw_entry = e;
        @(posedge clk); #1;
        tlbw_en    = 1'b0;
    endtask

    task automatic send(input logic [31:0] va, input logic st, input logic [31:0] pa,
                        input logic unc, input logic [1:0] exc);
        exp_t e;
        logic acc;
        int   n;
        e.paddr = pa;
        e.unc   = unc;
        e.exc   = exc;
        bus.req_valid = 1'b1;
        bus.req_vaddr = va;
        bus.req_store = st;
        sb.push_back(e);
        n = 0;
        forever begin
            @(negedge clk);
            acc = bus.req_ready;
            @(posedge clk); #1;
            if (acc) break;
            n++;
            if (n > 50) begin
                check_val("req_accept_timeout", acc, 1);
                break;
            end
        end
    endtask

    task automatic drain();
        int n;
        bus.req_valid = 1'b0;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (sb.size() != 0) check_val("drain_timeout", sb.size(), 0);
    endtask

    task automatic probe(input logic [19:0] vpn, input logic [7:0] a);
        tlbp_en  = 1'b1;
        tlbp_key = {vpn, a};
        @(posedge clk); #1;
        tlbp_en  = 1'b0;
    endtask

    task automatic send0(input logic [31:0] va, input logic [31:0] pa, input logic unc);
        bus0.req_valid = 1'b1;
        bus0.req_vaddr = va;
        bus0.req_store = 1'b1;
        @(posedge clk); #1;
        bus0.req_valid = 1'b0;
        @(negedge clk);
        check_val("legacy_valid", bus0.resp_valid, 1);
        check_val("legacy_paddr", bus0.resp_paddr, pa);
        check_val("legacy_unc", bus0.resp_uncached, unc);
        check_val("legacy_exc", bus0.resp_exc, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        int d0;
        asid = '0;
        tlbw_en = 1'b0;
        tlbw_index = '0;
        tlbw_entry = '0;
        tlb_flush = 1'b0;
        tlbp_en = 1'b0;
        tlbp_key = '0;
        bus.req_valid = 1'b0;
        bus.req_vaddr = '0;
        bus.req_store = 1'b0;
        bus.resp_ready = 1'b1;
        bus0.req_valid = 1'b0;
        bus0.req_vaddr = '0;
        bus0.req_store = 1'b0;
        bus0.resp_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_resp_valid", bus.resp_valid, 0);
        check_val("rst_resp_paddr", bus.resp_paddr, 0);
        check_val("rst_resp_exc", bus.resp_exc, 0);
        check_val("rst_tlbp_hit", tlbp_hit, 0);
        resetn = 1'b1;
        @(posedge clk); #1;
        check_val("rst_req_ready", bus.req_ready, 1);

        // Fill every entry with a non-global pattern nobody will look up.
        for (int i = 0; i < N; i++) write_entry(IW'(i), make_entry(20'hFFFFF, 8'hFF, 0, 0, 0, 0));

        // Unmapped kernel segments
        send(32'h9FC0_0100, 0, 32'h1FC0_0100, 0, 2'b00);
        send(32'hBFAF_8000, 0, 32'h1FAF_8000, 1, 2'b00);
        drain();

        // ASID-qualified entry: hit, modified on store, refill on other ASID
        write_entry(3, make_entry(20'h00400, 8'd5, 0, 20'h12345, 1, 0));
        asid = 8'd5;
        send(32'h0040_0ABC, 0, 32'h1234_5ABC, 0, 2'b00);
        send(32'h0040_0ABC, 1, 32'h1234_5ABC, 0, 2'b11);
        asid = 8'd6;
        send(32'h0040_0ABC, 0, 32'h0040_0ABC, 0, 2'b01);
        drain();

        // Invalid entry, and a dirty entry accepting a store
        write_entry(5, make_entry(20'h00600, 8'd0, 1, 20'h0ABCD, 0, 1));
        write_entry(6, make_entry(20'h00700, 8'd6, 0, 20'h00777, 1, 1));
        send(32'h0060_0123, 0, 32'h0ABC_D123, 0, 2'b10);
        send(32'h0070_0456, 1, 32'h0077_7456, 0, 2'b00);
        drain();

        // Multiple matches: lowest index wins for lookup and probe
        write_entry(2, make_entry(20'h00400, 8'd0, 1, 20'h00111, 1, 1));
        write_entry(7, make_entry(20'h00400, 8'd0, 1, 20'h00222, 1, 1));
        asid = 8'd5;
        send(32'h0040_0000, 0, 32'h0011_1000, 0, 2'b00);
        drain();
        probe(20'h00400, 8'h77);
        check_val("probe_hit", tlbp_hit, 1);
        check_val("probe_index", tlbp_index, 2);
        repeat (3) @(posedge clk);
        #1;
        check_val("probe_hold_hit", tlbp_hit, 1);
        check_val("probe_hold_index", tlbp_index, 2);
        probe(20'h12345, 8'h77);
        check_val("probe_miss_hit", tlbp_hit, 0);
        check_val("probe_miss_index", tlbp_index, 0);
        probe(20'h00600, 8'h33);
        check_val("probe_inv_hit", tlbp_hit, 1);
        check_val("probe_inv_index", tlbp_index, 5);

        // Same-edge write is not seen by the concurrent lookup
        tlbw_en    = 1'b1;
        tlbw_index = 4;
        tlbw_entry = make_entry(20'h00800, 8'd9, 1, 20'h00444, 1, 1);
        send(32'h0080_0010, 0, 32'h0080_0010, 0, 2'b01);
        tlbw_en    = 1'b0;
        send(32'h0080_0010, 0, 32'h0044_4010, 0, 2'b00);
        drain();
        tlb_flush = 1'b1;
        @(posedge clk); #1;
        tlb_flush = 1'b0;
        send(32'h0080_0010, 0, 32'h0080_0010, 0, 2'b01);
        send(32'h0040_0ABC, 0, 32'h1234_5ABC, 0, 2'b10);
        drain();
        // Flush and write on the same edge: the written entry survives
        tlb_flush  = 1'b1;
        tlbw_en    = 1'b1;
        tlbw_index = 4;
        tlbw_entry = make_entry(20'h00800, 8'd9, 1, 20'h00555, 1, 1);
        @(posedge clk); #1;
        tlb_flush  = 1'b0;
        tlbw_en    = 1'b0;
        send(32'h0080_0010, 0, 32'h0055_5010, 0, 2'b00);
        drain();

        // Back-to-back stream with a two-cycle consumer stall
        write_entry(6, make_entry(20'h00700, 8'd6, 0, 20'h00777, 1, 1));
        asid = 8'd6;
        d0 = delivered;
        fork
            begin
                send(32'h8000_0010, 0, 32'h0000_0010, 0, 2'b00);
                send(32'hA000_0020, 0, 32'h0000_0020, 1, 2'b00);
                send(32'h0070_0030, 0, 32'h0077_7030, 0, 2'b00);
                send(32'h8000_0040, 1, 32'h0000_0040, 0, 2'b00);
            end
            begin
                repeat (2) @(posedge clk);
                #1;
                bus.resp_ready = 1'b0;
                repeat (2) @(posedge clk);
                #1;
                bus.resp_ready = 1'b1;
            end
        join
        drain();
        check_val("stream_count", delivered - d0, 4);

        // Legacy instance: user segments pass straight through
        asid = 8'd5;
        write_entry(3, make_entry(20'h00400, 8'd5, 0, 20'h12345, 1, 0));
        send0(32'h0040_0ABC, 32'h0040_0ABC, 0);
        send0(32'hBFAF_8000, 32'h1FAF_8000, 1);
        send0(32'hC000_1234, 32'hC000_1234, 0);

        // Asynchronous reset with a result pending
        write_entry(8, make_entry(20'h00900, 8'd0, 1, 20'h00999, 1, 1));
        bus.resp_ready = 1'b0;
        send(32'h0040_0ABC, 0, 32'h1234_5ABC, 0, 2'b00);
        bus.req_valid = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        check_val("async_rst_valid", bus.resp_valid, 0);
        check_val("async_rst_paddr", bus.resp_paddr, 0);
        check_val("async_rst_tlbp_hit", tlbp_hit, 0);
        check_val("async_rst_tlbp_index", tlbp_index, 0);
        sb.delete();
        @(posedge clk); #1;
        resetn = 1'b1;
        bus.resp_ready = 1'b1;
        check_val("post_rst_req_ready", bus.req_ready, 1);
        asid = 8'd6;
        send(32'h0090_0010, 0, 32'h0090_0010, 0, 2'b01);
        send(32'h0040_0ABC, 0, 32'h0040_0ABC, 0, 2'b01);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/tlb_mmu.md
TLB_MMU -- requirements
Module: tlb_mmu

Interface
REQ-001 Parameter TLB_ENTRIES, default 16, number of fully associative entries (power of 2, 2..64); IW = log2(TLB_ENTRIES).
REQ-002 Parameter ASID_W, default 8, address-space-ID width.
REQ-003 Parameter MAPPED_USEG, default 1: 1 = kuseg/kseg2/kseg3 translated by TLB; 0 = legacy fixed mapping only.
REQ-004 clk  input  1  single clock, rising edge.
REQ-005 resetn  input  1  asynchronous, active-low reset.
REQ-006 asid  input  ASID_W  current address-space ID, sampled with each accepted request.
REQ-007 req_valid  input  1  translation request present.
REQ-008 req_ready  output  1  request accepted when req_valid && req_ready.
REQ-009 req_vaddr  input  32  virtual address.
REQ-010 req_store  input  1  request is a store.
REQ-011 resp_valid  output  1  translation result present.
REQ-012 resp_ready  input  1  consumer takes result.
REQ-013 resp_paddr  output  32  physical address.
REQ-014 resp_uncached  output  1  target is kseg1.
REQ-015 resp_exc  output  2  00 none, 01 refill (miss), 10 invalid (V=0), 11 modified (store, D=0).
REQ-016 tlbw_en  input  1  write entry.
REQ-017 tlbw_index  input  IW  entry to write.
REQ-018 tlbw_entry  input  43+ASID_W  {vpn[19:0], asid, g, pfn[19:0], v, d}, MSB first.
REQ-019 tlb_flush  input  1  clear V and G of all entries.
REQ-020 tlbp_en  input  1  probe request.
REQ-021 tlbp_key  input  20+ASID_W  {vpn, asid} to probe.
REQ-022 tlbp_hit  output  1  probe result, valid the cycle after tlbp_en.
REQ-023 tlbp_index  output  IW  lowest matching index; 0 on miss.

Function
REQ-024 Translation is one registered stage: accepted request at edge N yields resp_valid high after edge N, held with all resp fields stable until resp_ready.
REQ-025 req_ready = !resp_valid || resp_ready (combinational); back-to-back requests achieve one result per cycle.
REQ-026 Segment decode on vaddr[31:29]: 100 (kseg0) -> paddr = {3'b000, vaddr[28:0]}, uncached 0, exc 00; 101 (kseg1) -> same paddr, uncached 1, exc 00.
REQ-027 MAPPED_USEG=0: all other segments pass through paddr = vaddr, uncached 0, exc 00; TLB never consulted.
REQ-028 MAPPED_USEG=1: other segments match an entry when entry.vpn == vaddr[31:12] and (entry.g || entry.asid == asid); paddr = {pfn, vaddr[11:0]}.
REQ-029 Multiple matches: lowest index wins; no match -> exc 01, paddr = vaddr.
REQ-030 Match with v=0 -> exc 10; v=1, d=0, req_store=1 -> exc 11; else exc 00; paddr is the matched translation in all three cases.
REQ-031 Lookup at edge N uses TLB contents before any write/flush at edge N (write visible from the next accepted request).
REQ-032 Same-cycle tlb_flush and tlbw_en: flush applies to all entries, then the written entry takes tlbw_entry values.
REQ-033 Probe uses the same match rule (REQ-028, ignoring v) against contents before same-edge writes; tlbp_hit/tlbp_index hold until next tlbp_en.
REQ-034 Probe, write and translation operate concurrently with no mutual stalls.

Reset
REQ-035 resetn low clears resp_valid, resp_paddr, resp_uncached, resp_exc, tlbp_hit, tlbp_index to 0 and all entry v and g bits to 0, immediately and independent of clk.
REQ-036 A result pending when reset asserts is discarded; req_ready is 1 the first cycle after reset release.

Verification
REQ-037 MAPPED_USEG=1, reset, request vaddr 0x9FC0_0100 -> next cycle resp_paddr 0x1FC0_0100, uncached 0, exc 00; vaddr 0xBFAF_8000 -> 0x1FAF_8000, uncached 1.
REQ-038 Write index 3 {vpn 0x00400, asid 5, g 0, pfn 0x12345, v 1, d 0}, asid=5, load 0x0040_0ABC -> paddr 0x1234_5ABC, exc 00; store same -> exc 11; asid=6 load -> exc 01.
REQ-039 Index 2 and 7 both vpn 0x00400, g 1, pfn 0x00111/0x00222 -> load 0x0040_0000 gives 0x0011_1000; tlbp_key {0x00400,any} -> hit 1, index 2.
REQ-040 Write index 4 same edge as request to its vpn -> that result exc 01; next request hits; flush -> subsequent request exc 01.
REQ-041 Stream 4 requests with resp_ready low 2 cycles -> req_ready low, resp fields held, all 4 results delivered in order with no loss; MAPPED_USEG=0 vaddr 0x0040_0ABC -> paddr 0x0040_0ABC.
REQ-042 Assert resetn low mid-stream with resp_valid high -> resp_valid 0 without clock edge; prior TLB entries read as miss after release.
